// File: rtl/cartoon_pkg.sv
// cartoon_pkg: shared widths and types for the mean-average controller
package cartoon_pkg;
    localparam int PIXEL_W  = 24;
    localparam int WINDOW_W = 216;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ctrl_state_t;
    typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous first-word fall-through FIFO with occupancy count
module pixel_fifo
    import cartoon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic          pop,
    input  pixel_t        din,
    output pixel_t        dout,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    pixel_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    // a dropped push would silently lose a datapath result
    always_ff @(posedge clk)
        if (n_rst) assert (!(push && !do_push));
endmodule

// File: rtl/mean_avg_ctrl.sv
// mean_avg_ctrl: credit-based scheduler between the window source and mean-average datapath
// Defining MEAN_AVG_CTRL_PERF_EN adds the saturating stall_cycles counter port.
module mean_avg_ctrl
    import cartoon_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    output logic                busy,
    output logic                frame_done,
    input  logic                win_valid,
    output logic                win_ready,
    input  logic [WINDOW_W-1:0] win_data,
    input  logic                win_edge,
    output logic [WINDOW_W-1:0] dp_pixelData,
    output logic                dp_isEdge,
    input  logic [PIXEL_W-1:0]  dp_f_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIXEL_W-1:0]  out_pixel,
    output logic                out_last
`ifdef MEAN_AVG_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int IW    = $clog2(LATENCY + 2);

    ctrl_state_t state;
    logic [NW-1:0] issued, popped;
    logic [LATENCY:0] tag;
    logic [LATENCY-2:0] edge_pipe;
    logic [LATENCY-1:0] edge_next;
    logic [IW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic fifo_empty, hs, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LATENCY; i++) inflight = inflight + IW'(tag[i]);
    end

    // every accepted window owns a FIFO slot until its result is popped
    assign win_ready  = state == RUN && int'(fifo_count) + int'(inflight) < FIFO_DEPTH
                        && issued < NW'(TOTAL);
    assign hs         = win_valid && win_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_last   = out_valid && popped == NW'(TOTAL - 1);
    assign busy       = state == RUN || state == DRAIN;
    assign frame_done = state == DONE;
    assign edge_next  = {edge_pipe, hs && win_edge};
    assign dp_isEdge  = edge_pipe[LATENCY-2];

    always_ff @(posedge clk)
        if (!n_rst) begin
            state        <= IDLE;
            issued       <= '0;
            popped       <= '0;
            tag          <= '0;
            edge_pipe    <= '0;
            dp_pixelData <= '0;
        end else begin
            tag       <= {tag[LATENCY-1:0], hs};
            edge_pipe <= edge_next[LATENCY-2:0];
            if (hs) begin
                dp_pixelData <= win_data;
                issued       <= issued + 1'b1;
            end
            if (pop) popped <= popped + 1'b1;
            if (state == IDLE && start) begin
                state  <= RUN;
                issued <= '0;
                popped <= '0;
            end else if (state == RUN && issued == NW'(TOTAL)) state <= DRAIN;
            else if (state == DRAIN && inflight == '0 && fifo_empty) state <= DONE;
            else if (state == DONE) state <= IDLE;
        end

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (tag[LATENCY]),
        .pop   (pop),
        .din   (dp_f_pixel),
        .dout  (out_pixel),
        .count (fifo_count),
        .empty (fifo_empty)
    );

`ifdef MEAN_AVG_CTRL_PERF_EN
    always_ff @(posedge clk)
        if (!n_rst || (state == IDLE && start)) stall_cycles <= '0;
        else if (state == RUN && win_valid && !win_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_mean_avg_ctrl.sv
// tb_mean_avg_ctrl: directed checks of the mean-average controller with a 3-stage datapath model
module tb_mean_avg_ctrl;
    localparam int TOTAL = 8;
    logic clk = 0, n_rst = 0, start = 0, win_valid = 0, out_ready = 0, win_edge;
    logic busy, frame_done, win_ready, dp_isEdge, out_valid, out_last;
    logic [215:0] win_data, dp_pixelData;
    logic [23:0] dp_f_pixel, out_pixel, s1, s2, s3;
`ifdef MEAN_AVG_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif
    int total = 0, bad = 0, cyc = 0, n_iss = 0, n_done = 0, win_k = 0, edge_k = -1;
    int last_pop_cyc = 0, done_cyc = 0;
    logic [23:0] rec_pix[$];
    logic rec_last[$];

    mean_avg_ctrl #(.WIDTH(4), .HEIGHT(2), .LATENCY(3), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_edge     (win_edge),
        .dp_pixelData (dp_pixelData),
        .dp_isEdge    (dp_isEdge),
        .dp_f_pixel   (dp_f_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_last     (out_last)
`ifdef MEAN_AVG_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [215:0] make_win(input int k);
        logic [215:0] w;
        for (int i = 0; i < 9; i++) w[215-24*i -: 24] = {8'(16 * k + i), 8'(k), 8'(2 * i)};
        return w;
    endfunction

    // channel means of make_win(k): R = 16k+4, G = k, B = 8; edge windows become black
    function automatic logic [23:0] exp_pix(input int k, input logic e);
        return e ? 24'd0 : {8'(16 * k + 4), 8'(k), 8'd8};
    endfunction

    function automatic logic [23:0] avg9(input logic [215:0] w);
        logic [11:0] r, g, b;
        r = 0;
        g = 0;
        b = 0;
        for (int i = 0; i < 9; i++) begin
            r = r + 12'(w[215-24*i -: 8]);
            g = g + 12'(w[207-24*i -: 8]);
            b = b + 12'(w[199-24*i -: 8]);
        end
        return {8'(r / 9), 8'(g / 9), 8'(b / 9)};
    endfunction

    assign win_data   = make_win(win_k);
    assign win_edge   = win_k == edge_k;
    assign dp_f_pixel = s3;

    always_ff @(posedge clk) begin
        s1 <= avg9(dp_pixelData);
        s2 <= dp_isEdge ? 24'd0 : s1;
        s3 <= s2;
    end

    task automatic cycle();
        logic h;
        h = win_valid && win_ready;
        if (out_valid && out_ready) begin
            rec_pix.push_back(out_pixel);
            rec_last.push_back(out_last);
            if (out_last) last_pop_cyc = cyc;
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
        if (h) begin
            n_iss++;
            win_k++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start_frame(input int k0);
        win_k = k0;
        n_iss = 0;
        n_done = 0;
        last_pop_cyc = -100;
        done_cyc = 0;
        rec_pix.delete();
        rec_last.delete();
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic test_reset();
        n_rst = 0;
        run(3);
        n_rst = 1;
        total++;
        if ({busy, frame_done, win_ready, out_valid, out_last, dp_isEdge} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {busy, frame_done, win_ready, out_valid, out_last, dp_isEdge});
        end
        total++;
        if (out_pixel !== 24'd0) begin
            bad++;
            $display("FAIL reset_out_pixel got=%h want=0", out_pixel);
        end
        total++;
        if (dp_pixelData !== 216'd0) begin
            bad++;
            $display("FAIL reset_dp_pixelData got nonzero want=0");
        end
        win_valid = 1;
        n_iss = 0;
        run(5);
        total++;
        if (n_iss !== 0 || win_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_issue issued=%0d ready=%b busy=%b want 0 0 0", n_iss, win_ready, busy);
        end
        total++;
        if (dp_pixelData !== 216'd0) begin
            bad++;
            $display("FAIL idle_dp_hold got nonzero want=0");
        end
    endtask

    task automatic test_streaming();
        win_valid = 1;
        out_ready = 1;
        start_frame(0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL stream_busy got=%b want=1", busy);
        end
        run(50);
        total++;
        if (rec_pix.size() != TOTAL) begin
            bad++;
            $display("FAIL stream_count got=%0d want=%0d", rec_pix.size(), TOTAL);
        end
        for (int i = 0; i < rec_pix.size(); i++) begin
            total++;
            if (rec_pix[i] !== exp_pix(i, 1'b0) || rec_last[i] !== (i == TOTAL - 1)) begin
                bad++;
                $display("FAIL stream_out[%0d] got=%h/%b want=%h/%b", i, rec_pix[i], rec_last[i],
                         exp_pix(i, 1'b0), i == TOTAL - 1);
            end
        end
        total++;
        if (n_done != 1 || done_cyc - last_pop_cyc != 2) begin
            bad++;
            $display("FAIL stream_done pulses=%0d gap=%0d want 1 2", n_done, done_cyc - last_pop_cyc);
        end
        total++;
        if (n_iss != TOTAL || busy !== 1'b0) begin
            bad++;
            $display("FAIL stream_issued got=%0d busy=%b want=%0d 0", n_iss, busy, TOTAL);
        end
    endtask

    task automatic test_backpressure();
        win_valid = 1;
        out_ready = 0;
        start_frame(0);
        run(20);
        total++;
        if (n_iss != 4 || win_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_credits issued=%0d ready=%b want 4 0", n_iss, win_ready);
        end
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || rec_pix.size() != 0) begin
            bad++;
            $display("FAIL bp_hold valid=%b busy=%b pops=%0d want 1 1 0", out_valid, busy, rec_pix.size());
        end
        out_ready = 1;
        run(60);
        total++;
        if (n_iss != TOTAL || rec_pix.size() != TOTAL || n_done != 1) begin
            bad++;
            $display("FAIL bp_release issued=%0d outs=%0d done=%0d want 8 8 1", n_iss, rec_pix.size(), n_done);
        end
        for (int i = 0; i < rec_pix.size(); i++) begin
            total++;
            if (rec_pix[i] !== exp_pix(i, 1'b0)) begin
                bad++;
                $display("FAIL bp_out[%0d] got=%h want=%h", i, rec_pix[i], exp_pix(i, 1'b0));
            end
        end
    endtask

    task automatic test_edge();
        win_valid = 1;
        out_ready = 1;
        edge_k = 3;
        start_frame(0);
        run(50);
        edge_k = -1;
        total++;
        if (rec_pix.size() != TOTAL) begin
            bad++;
            $display("FAIL edge_count got=%0d want=%0d", rec_pix.size(), TOTAL);
        end
        for (int i = 0; i < rec_pix.size(); i++) begin
            total++;
            if (rec_pix[i] !== exp_pix(i, i == 3)) begin
                bad++;
                $display("FAIL edge_out[%0d] got=%h want=%h", i, rec_pix[i], exp_pix(i, i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        win_valid = 1;
        out_ready = 1;
        start_frame(0);
        for (int i = 0; i < 40 && n_iss < 5; i++) cycle();
        total++;
        if (n_iss != 5) begin
            bad++;
            $display("FAIL mid_issue_timeout got=%0d want=5", n_iss);
        end
        n_rst = 0;
        win_valid = 0;
        cycle();
        total++;
        if ({busy, frame_done, win_ready, out_valid, out_last, dp_isEdge} !== 6'b0 || out_pixel !== 24'd0) begin
            bad++;
            $display("FAIL mid_reset flags=%b pixel=%h want 000000 0",
                     {busy, frame_done, win_ready, out_valid, out_last, dp_isEdge}, out_pixel);
        end
        total++;
        if (dp_pixelData !== 216'd0) begin
            bad++;
            $display("FAIL mid_reset_dp got nonzero want=0");
        end
        n_rst = 1;
        win_valid = 1;
        start_frame(8);
        run(50);
        total++;
        if (rec_pix.size() != TOTAL || n_done != 1) begin
            bad++;
            $display("FAIL mid_restart outs=%0d done=%0d want 8 1", rec_pix.size(), n_done);
        end
        for (int i = 0; i < rec_pix.size(); i++) begin
            total++;
            if (rec_pix[i] !== exp_pix(8 + i, 1'b0)) begin
                bad++;
                $display("FAIL mid_out[%0d] got=%h want=%h", i, rec_pix[i], exp_pix(8 + i, 1'b0));
            end
        end
    endtask

    task automatic test_start_ignored();
        win_valid = 1;
        out_ready = 1;
        start_frame(0);
        run(3);
        start = 1;
        run(4);
        start = 0;
        run(50);
        total++;
        if (rec_pix.size() != TOTAL || n_done != 1 || n_iss != TOTAL) begin
            bad++;
            $display("FAIL start_ignored outs=%0d done=%0d issued=%0d want 8 1 8", rec_pix.size(), n_done, n_iss);
        end
        for (int i = 0; i < rec_pix.size(); i++) begin
            total++;
            if (rec_pix[i] !== exp_pix(i, 1'b0) || rec_last[i] !== (i == TOTAL - 1)) begin
                bad++;
                $display("FAIL start_ignored_out[%0d] got=%h/%b want=%h/%b", i, rec_pix[i], rec_last[i],
                         exp_pix(i, 1'b0), i == TOTAL - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_edge();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
